// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // Width codes carried from execute on rd_wr_mem.
  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } width_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_WIDTH    = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  // Write-side payload presented on the memory bus.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
  } store_lanes_t;

  // Replicate store data across byte lanes and select the enabled lanes.
  function automatic store_lanes_t pack_store(input logic [2:0] width,
                                              input logic [1:0] offset,
                                              input logic [DATA_WIDTH-1:0] data);
    store_lanes_t s;
    s.wdata = data;
    s.wstrb = 4'b1111;
    case (width)
      LS_B: begin
        s.wdata = {4{data[7:0]}};
        s.wstrb = 4'b0001 << offset;
      end
      LS_H: begin
        s.wdata = {2{data[15:0]}};
        s.wstrb = 4'b0011 << offset;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Request/acknowledge bus between the load/store unit and word-organised data memory.
interface lsu_mem_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_formatter.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_formatter
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  width,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection equals rdata >> 8*offset for the bits that matter.
  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension by width code; illegal codes never reach here but read as zero.
  always_comb begin
    data = '0;
    case (width)
      LS_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LS_H:    data = {{16{half_sel[15]}}, half_sel};
      LS_W:    data = rdata;
      LS_BU:   data = {24'b0, byte_sel};
      LS_HU:   data = {16'b0, half_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: issues one request/ack transaction per op, stalls upstream, formats loads.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  op_valid,
  input  logic                  mem_wr_execute,
  input  logic [2:0]            rd_wr_mem_execute,
  input  logic [ADDR_WIDTH-1:0] addr_execute,
  input  logic [31:0]           wdata_execute,
  input  logic [4:0]            waddr_execute,
  output logic                  stall,
  lsu_mem_if.master             mem,
  output logic                  load_valid,
  output logic [31:0]           load_data,
  output logic [4:0]            load_waddr,
  output logic                  fault,
  output logic [1:0]            fault_code
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         offset_q;
  logic [2:0]         width_q;
  logic [4:0]         waddr_q;
  logic               width_ok;
  logic               misaligned;
  logic               accept;
  logic [31:0]        fmt_data;
  store_lanes_t       lanes;

  // Legality of the op presented by execute; width errors outrank alignment.
  always_comb begin
    width_ok   = 1'b0;
    misaligned = 1'b0;
    case (rd_wr_mem_execute)
      LS_B, LS_H, LS_W: width_ok = 1'b1;
      LS_BU, LS_HU:     width_ok = !mem_wr_execute;
      default:          width_ok = 1'b0;
    endcase
    case (rd_wr_mem_execute)
      LS_H, LS_HU: misaligned = addr_execute[0];
      LS_W:        misaligned = |addr_execute[1:0];
      default:     misaligned = 1'b0;
    endcase
    lanes  = pack_store(rd_wr_mem_execute, addr_execute[1:0], wdata_execute);
    accept = (state == IDLE) && op_valid && width_ok && !misaligned;
    stall  = accept || (state == BUSY);
  end

  load_formatter u_fmt (
    .rdata  (mem.mem_rdata),
    .offset (offset_q),
    .width  (width_q),
    .data   (fmt_data)
  );

  // Transaction FSM with registered bus and writeback outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      offset_q      <= '0;
      width_q       <= '0;
      waddr_q       <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_wstrb <= '0;
      load_valid    <= 1'b0;
      load_data     <= '0;
      load_waddr    <= '0;
      fault         <= 1'b0;
      fault_code    <= '0;
    end else begin
      fault      <= 1'b0;
      load_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state         <= BUSY;
            cnt           <= '0;
            offset_q      <= addr_execute[1:0];
            width_q       <= rd_wr_mem_execute;
            waddr_q       <= waddr_execute;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= mem_wr_execute;
            mem.mem_addr  <= {addr_execute[ADDR_WIDTH-1:2], 2'b00};
            mem.mem_wdata <= mem_wr_execute ? lanes.wdata : 32'h0;
            mem.mem_wstrb <= mem_wr_execute ? lanes.wstrb : 4'b0000;
          end else if (op_valid) begin
            fault      <= 1'b1;
            fault_code <= width_ok ? FC_MISALIGN : FC_WIDTH;
          end
        end
        BUSY: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            cnt         <= '0;
            if (!mem.mem_we) begin
              load_data  <= fmt_data;
              load_waddr <= waddr_q;
              load_valid <= 1'b1;
              state      <= RESP;
            end else begin
              state <= IDLE;
            end
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem.mem_req <= 1'b0;
            cnt         <= '0;
            fault       <= 1'b1;
            fault_code  <= FC_TIMEOUT;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; inputs driven and outputs sampled mid-cycle.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        mem_wr_execute = 1'b0;
  logic [2:0]  rd_wr_mem_execute = 3'b000;
  logic [31:0] addr_execute = 32'h0;
  logic [31:0] wdata_execute = 32'h0;
  logic [4:0]  waddr_execute = 5'd0;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic [4:0]  load_waddr;
  logic        fault;
  logic [1:0]  fault_code;

  int total = 0;
  int bad   = 0;

  lsu_mem_if #(.ADDR_WIDTH(32)) bus ();

  load_store_unit #(.TIMEOUT_CYCLES(16), .ADDR_WIDTH(32)) dut (
    .clock             (clock),
    .reset             (reset),
    .op_valid          (op_valid),
    .mem_wr_execute    (mem_wr_execute),
    .rd_wr_mem_execute (rd_wr_mem_execute),
    .addr_execute      (addr_execute),
    .wdata_execute     (wdata_execute),
    .waddr_execute     (waddr_execute),
    .stall             (stall),
    .mem               (bus),
    .load_valid        (load_valid),
    .load_data         (load_data),
    .load_waddr        (load_waddr),
    .fault             (fault),
    .fault_code        (fault_code)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Present one op in the current cycle.
  task automatic issue(input logic we, input logic [2:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd);
    op_valid          = 1'b1;
    mem_wr_execute    = we;
    rd_wr_mem_execute = w;
    addr_execute      = a;
    wdata_execute     = d;
    waddr_execute     = rd;
  endtask

  task automatic run_store(input string tag, input logic [2:0] w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    @(negedge clock); issue(1'b1, w, a, d, 5'd0); #1;
    check({tag, "_stall0"}, 32'(stall), 32'd1);
    @(negedge clock); op_valid = 1'b0; bus.mem_ack = 1'b1; #1;
    check({tag, "_req_we_stall"}, {29'd0, bus.mem_req, bus.mem_we, stall}, 32'd7);
    check({tag, "_addr"}, bus.mem_addr, exp_addr);
    check({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
    check({tag, "_wstrb"}, 32'(bus.mem_wstrb), 32'(exp_wstrb));
    @(negedge clock); bus.mem_ack = 1'b0; #1;
    check({tag, "_after"}, {29'd0, bus.mem_req, stall, load_valid}, 32'd0);
  endtask

  task automatic run_bad(input string tag, input logic we, input logic [2:0] w,
                         input logic [31:0] a, input logic [1:0] exp_code);
    @(negedge clock); issue(we, w, a, 32'h0, 5'd1); #1;
    check({tag, "_stall_req"}, {30'd0, stall, bus.mem_req}, 32'd0);
    @(negedge clock); op_valid = 1'b0; #1;
    check({tag, "_fault"}, {28'd0, fault, fault_code, bus.mem_req}, {28'd0, 1'b1, exp_code, 1'b0});
    @(negedge clock); #1;
    check({tag, "_pulse_end"}, {30'd0, fault, bus.mem_req}, 32'd0);
  endtask

  initial begin
    int req_cnt;
    int lv_cnt;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check("reset_outs", {26'd0, stall, bus.mem_req, load_valid, fault, fault_code},
          32'd0);
    check("reset_bus", {bus.mem_we, bus.mem_wstrb, bus.mem_addr[26:0]}, 32'd0);
    reset = 1'b0;

    // LB at 0x103, ack after one cycle
    @(negedge clock); issue(1'b0, 3'b000, 32'h103, 32'h0, 5'd5); #1;
    check("lb_c0_stall_req", {30'd0, stall, bus.mem_req}, 32'd2);
    @(negedge clock); op_valid = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h80FF_1234; #1;
    check("lb_c1_stall_req", {30'd0, stall, bus.mem_req}, 32'd3);
    check("lb_c1_addr", bus.mem_addr, 32'h100);
    @(negedge clock); bus.mem_ack = 1'b0; #1;
    check("lb_c2_valid_stall", {30'd0, load_valid, stall}, 32'd2);
    check("lb_data", load_data, 32'hFFFF_FF80);
    check("lb_waddr", 32'(load_waddr), 32'd5);
    @(negedge clock); #1;
    check("lb_c3_valid", 32'(load_valid), 32'd0);

    // LHU at 0x102 with three wait cycles
    @(negedge clock); issue(1'b0, 3'b101, 32'h102, 32'h0, 5'd7); #1;
    req_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      op_valid      = 1'b0;
      bus.mem_ack   = (i == 4);
      bus.mem_rdata = (i == 4) ? 32'hBEEF_0000 : 32'hDEAD_DEAD;
      #1;
      if (bus.mem_req) req_cnt++;
      if (i == 1) check("lhu_addr", bus.mem_addr, 32'h100);
    end
    @(negedge clock); bus.mem_ack = 1'b0; #1;
    check("lhu_req_cycles", 32'(req_cnt), 32'd4);
    check("lhu_valid", 32'(load_valid), 32'd1);
    check("lhu_data", load_data, 32'h0000_BEEF);

    // Stores: lane replication and strobes
    run_store("sb", 3'b000, 32'h201, 32'h0000_00AB, 32'h200, 32'hABAB_ABAB, 4'b0010);
    run_store("sh", 3'b001, 32'h202, 32'h1234_CDEF, 32'h200, 32'hCDEF_CDEF, 4'b1100);
    run_store("sw", 3'b010, 32'h300, 32'hDEAD_BEEF, 32'h300, 32'hDEAD_BEEF, 4'b1111);

    // Illegal ops
    run_bad("lw_mis",   1'b0, 3'b010, 32'h006, 2'b01);
    run_bad("lh_mis",   1'b0, 3'b001, 32'h101, 2'b01);
    run_bad("w011",     1'b0, 3'b011, 32'h100, 2'b10);
    run_bad("sbu",      1'b1, 3'b100, 32'h100, 2'b10);
    run_bad("w111_mis", 1'b0, 3'b111, 32'h001, 2'b10);

    // Timeout: ack withheld
    @(negedge clock); issue(1'b0, 3'b010, 32'h400, 32'h0, 5'd3); #1;
    req_cnt = 0;
    lv_cnt  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock); op_valid = 1'b0; #1;
      if (bus.mem_req) req_cnt++;
      if (load_valid) lv_cnt++;
      if (i == 17) begin
        check("to_fault", {29'd0, fault, fault_code}, 32'd7);
        check("to_stall", 32'(stall), 32'd0);
      end
    end
    check("to_req_cycles", 32'(req_cnt), 32'd16);
    check("to_no_load", 32'(lv_cnt), 32'd0);

    // Reset in the second BUSY cycle, then a late ack
    @(negedge clock); issue(1'b0, 3'b010, 32'h500, 32'h0, 5'd9); #1;
    @(negedge clock); op_valid = 1'b0; #1;
    check("rst_busy1_req", 32'(bus.mem_req), 32'd1);
    @(negedge clock); reset = 1'b1; #1;
    check("rst_busy2_req", 32'(bus.mem_req), 32'd1);
    @(negedge clock); reset = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678; #1;
    check("rst_after", {30'd0, bus.mem_req, stall}, 32'd0);
    @(negedge clock); #1;
    check("rst_late_ack", {30'd0, load_valid, fault}, 32'd0);
    @(negedge clock); bus.mem_ack = 1'b0; #1;
    check("rst_idle", {29'd0, load_valid, bus.mem_req, stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
